baud_cfg_sequencer: RTL and testbench

Sequences runtime baudrate changes for the UART core's baudrate generator. Accepts a new acquisition period and bit-compensation word from the host register bank over a valid/ready handshake. Holds off the UART datapath until TX and RX are idle, then presents the new values to the generator so they are latched at a clean bit boundary, and optionally measures the resulting bit period. Sits between the register bank and `BaudrateModule`, and drives the generator's `AcqPeriod_i` / `BitCompensation_i` inputs.

---
 rtl/uart_cfg_pkg.sv | 43 ++++
 rtl/bit_period_meter.sv | 34 +++
 rtl/baud_cfg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_baud_cfg_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// ----------------------------------------------------------------------------
// uart_cfg_pkg : shared types and constants for the UART baudrate config path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_ARM     = 3'd3,
    ST_LATCH   = 3'd4,
    ST_VERIFY  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;

  localparam logic [11:0] C_DEFAULT_PERIOD = 12'd215;
  localparam logic [7:0]  C_DEFAULT_COMP   = 8'h77;
  localparam int          C_MEAS_W         = 17;

  // Bit period in clocks: (U+D)*(P+1)+U, or P+1 when no compensation is set.
  function automatic logic [16:0] expected_period(input logic [11:0] period,
                                                  input logic [7:0]  comp);
    logic [16:0] up;
    logic [16:0] ud;
    logic [16:0] p1;
    up = {13'd0, comp[7:4]};
    ud = up + {13'd0, comp[3:0]};
    p1 = {5'd0, period} + 17'd1;
    if (ud == 17'd0) begin
      return p1;
    end
    return (ud * p1) + up;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_period_meter.sv
// ----------------------------------------------------------------------------
// bit_period_meter : saturating clock counter between two baud pulses
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bit_period_meter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         run,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // The start cycle itself counts as the first clock of the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= W'(1);
    end else if (run && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/baud_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// baud_cfg_sequencer : applies runtime baudrate changes at a clean bit boundary
// Optional period check built with `define BAUD_CFG_VERIFY_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module baud_cfg_sequencer
  import uart_cfg_pkg::*;
#(
  parameter logic [11:0] DEFAULT_PERIOD = C_DEFAULT_PERIOD,
  parameter logic [7:0]  DEFAULT_COMP   = C_DEFAULT_COMP,
  parameter logic [19:0] IDLE_TIMEOUT   = 20'd1000000,
  parameter logic [7:0]  TOL_CLKS       = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [11:0] cfg_period_i,
  input  logic [7:0]  cfg_comp_i,
  input  logic        tx_busy_i,
  input  logic        rx_busy_i,
  output logic        uart_hold_o,
  input  logic        baud_sig_i,
  output logic [11:0] acq_period_o,
  output logic [7:0]  bit_comp_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [16:0] meas_period_o
);

  state_t      r_state;
  logic [11:0] r_shadow_period;
  logic [7:0]  r_shadow_comp;
  logic [19:0] r_tmo;
  logic        w_tmo_hit;

  assign w_tmo_hit = ({1'b0, r_tmo} + 21'd1) >= {1'b0, IDLE_TIMEOUT};

`ifdef BAUD_CFG_VERIFY_EN
  logic [C_MEAS_W-1:0] w_count;
  logic [16:0]         w_exp;
  logic [16:0]         w_diff;
  logic                w_ok;
  logic [16:0]         r_meas;

  bit_period_meter #(
    .W (C_MEAS_W)
  ) u_meter (
    .clk   (clk),
    .rst   (rst),
    .start (r_state == ST_LATCH && baud_sig_i),
    .run   (r_state == ST_VERIFY),
    .count (w_count)
  );

  assign w_exp  = expected_period(r_shadow_period, r_shadow_comp);
  assign w_diff = (w_count >= w_exp) ? (w_count - w_exp) : (w_exp - w_count);
  // A saturated counter means the pulse never came in range: always a mismatch.
  assign w_ok   = (w_count != '1) && (w_diff <= {9'd0, TOL_CLKS});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meas <= '0;
    end else if (r_state == ST_VERIFY && baud_sig_i) begin
      r_meas <= w_count;
    end
  end

  assign meas_period_o = r_meas;
`else
  logic w_unused_tol;
  assign w_unused_tol  = ^TOL_CLKS;
  assign meas_period_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      cfg_ready_o     <= 1'b1;
      uart_hold_o     <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      err_code_o      <= ERR_NONE;
      acq_period_o    <= DEFAULT_PERIOD;
      bit_comp_o      <= DEFAULT_COMP;
      r_shadow_period <= DEFAULT_PERIOD;
      r_shadow_comp   <= DEFAULT_COMP;
      r_tmo           <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Ready returns one cycle after the done/err pulse.
          cfg_ready_o <= 1'b1;
          if (cfg_valid_i && cfg_ready_o) begin
            r_shadow_period <= cfg_period_i;
            r_shadow_comp   <= cfg_comp_i;
            err_code_o      <= ERR_NONE;
            cfg_ready_o     <= 1'b0;
            uart_hold_o     <= 1'b1;
            r_tmo           <= '0;
            r_state         <= ST_QUIESCE;
          end
        end
        ST_QUIESCE: begin
          if (!tx_busy_i && !rx_busy_i) begin
            r_state <= ST_ALIGN;
          end else if (w_tmo_hit) begin
            err_o       <= 1'b1;
            err_code_o  <= ERR_TIMEOUT;
            uart_hold_o <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 20'd1;
          end
        end
        ST_ALIGN: begin
          if (baud_sig_i) begin
            acq_period_o <= r_shadow_period;
            bit_comp_o   <= r_shadow_comp;
            r_state      <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (baud_sig_i) begin
`ifdef BAUD_CFG_VERIFY_EN
            r_state <= ST_VERIFY;
`else
            done_o      <= 1'b1;
            uart_hold_o <= 1'b0;
            r_state     <= ST_IDLE;
`endif
          end
        end
`ifdef BAUD_CFG_VERIFY_EN
        ST_VERIFY: begin
          if (baud_sig_i) begin
            uart_hold_o <= 1'b0;
            r_state     <= ST_IDLE;
            if (w_ok) begin
              done_o <= 1'b1;
            end else begin
              err_o      <= 1'b1;
              err_code_o <= ERR_MISMATCH;
            end
          end
        end
`endif
        default: begin
          uart_hold_o <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_baud_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_baud_cfg_sequencer : directed + random checks against a generator model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_baud_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [11:0] cfg_period_i = '0;
  logic [7:0]  cfg_comp_i = '0;
  logic        tx_busy_i = 1'b0;
  logic        rx_busy_i = 1'b0;
  logic        uart_hold_o;
  logic        baud_sig_i;
  logic [11:0] acq_period_o;
  logic [7:0]  bit_comp_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [16:0] meas_period_o;

  int n_checks = 0;
  int n_errors = 0;
  int force_per = 0;
  int gen_cnt;
  int gen_per;

  always #5 clk = ~clk;

  baud_cfg_sequencer #(
    .DEFAULT_PERIOD (12'd215),
    .DEFAULT_COMP   (8'h77),
    .IDLE_TIMEOUT   (20'd100),
    .TOL_CLKS       (8'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_period_i  (cfg_period_i),
    .cfg_comp_i    (cfg_comp_i),
    .tx_busy_i     (tx_busy_i),
    .rx_busy_i     (rx_busy_i),
    .uart_hold_o   (uart_hold_o),
    .baud_sig_i    (baud_sig_i),
    .acq_period_o  (acq_period_o),
    .bit_comp_o    (bit_comp_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o),
    .meas_period_o (meas_period_o)
  );

  // Bit period of the generator for a given setting, from the documented rule.
  function automatic int model_period(input int p, input int comp);
    int u;
    int d;
    u = comp / 16;
    d = comp % 16;
    if (u + d == 0) return p + 1;
    return (u + d) * (p + 1) + u;
  endfunction

  // Generator model: picks up its inputs on the clock before each pulse.
  always @(posedge clk) begin
    if (rst) begin
      gen_cnt    <= 1;
      gen_per    <= model_period(215, 'h77);
      baud_sig_i <= 1'b0;
    end else if (gen_cnt >= gen_per) begin
      baud_sig_i <= 1'b1;
      gen_cnt    <= 1;
      gen_per    <= (force_per > 0) ? force_per
                                    : model_period(int'(acq_period_o), int'(bit_comp_o));
    end else begin
      baud_sig_i <= 1'b0;
      gen_cnt    <= gen_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cfg_ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_req", 32'(cfg_ready_o), 32'd1);
  endtask

  task automatic run_change(input int p, input int comp, input int exp_meas,
                            input bit exp_mismatch, input int busy_cycles);
    int  old_p, old_c, k, rel_cycle, upd_cycle;
    bit  seen_update, finished, prev_baud, bad_hold, bad_busy;
    wait_ready();
    old_p = int'(acq_period_o);
    old_c = int'(bit_comp_o);
    if (busy_cycles > 0) begin
      tx_busy_i = 1'b1;
      rx_busy_i = 1'b0;
    end
    cfg_period_i = 12'(p);
    cfg_comp_i   = 8'(comp);
    cfg_valid_i  = 1'b1;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    check("hold_after_hs", 32'(uart_hold_o), 32'd1);
    check("ready_after_hs", 32'(cfg_ready_o), 32'd0);
    bad_busy = 1'b0;
    for (int i = 0; i < busy_cycles; i++) begin
      if (!uart_hold_o || int'(acq_period_o) != old_p || int'(bit_comp_o) != old_c)
        bad_busy = 1'b1;
      if (i % 7 == 6) begin
        tx_busy_i = ~tx_busy_i;
        rx_busy_i = ~tx_busy_i;
      end
      @(negedge clk);
    end
    if (busy_cycles > 0) check("busy_hold_steady", 32'(bad_busy), 32'd0);
    tx_busy_i = 1'b0;
    rx_busy_i = 1'b0;
    rel_cycle = 0;
    upd_cycle = 0;
    seen_update = 1'b0;
    finished = 1'b0;
    prev_baud = 1'b0;
    bad_hold = 1'b0;
    k = 0;
    while (!finished && k < 20000) begin
      if (!seen_update && (int'(acq_period_o) != old_p || int'(bit_comp_o) != old_c)) begin
        seen_update = 1'b1;
        upd_cycle = k;
        check("update_after_baud", 32'(prev_baud), 32'd1);
        check("acq_new", 32'(acq_period_o), 32'(p));
        check("comp_new", 32'(bit_comp_o), 32'(comp));
      end
      if (done_o || err_o) finished = 1'b1;
      else if (!uart_hold_o || cfg_ready_o) bad_hold = 1'b1;
      prev_baud = baud_sig_i;
      if (!finished) begin
        @(negedge clk);
        k++;
      end
    end
    check("change_finished", 32'(finished), 32'd1);
    check("update_seen", 32'(seen_update), 32'd1);
    if (busy_cycles > 0)
      check("update_within_2_periods",
            32'(upd_cycle - rel_cycle <= 2 * model_period(old_p, old_c) + 2), 32'd1);
    check("hold_while_busy", 32'(bad_hold), 32'd0);
    check("hold_drop", 32'(uart_hold_o), 32'd0);
    check("ready_low_on_done", 32'(cfg_ready_o), 32'd0);
    check("done_pulse", 32'(done_o), 32'(!exp_mismatch));
    check("err_pulse", 32'(err_o), 32'(exp_mismatch));
    check("err_code", 32'(err_code_o), exp_mismatch ? 32'd2 : 32'd0);
    check("acq_final", 32'(acq_period_o), 32'(p));
    check("comp_final", 32'(bit_comp_o), 32'(comp));
`ifdef BAUD_CFG_VERIFY_EN
    check("meas_period", 32'(meas_period_o), 32'(exp_meas));
`else
    check("meas_zero", 32'(meas_period_o), 32'(exp_meas * 0));
`endif
    @(negedge clk);
    check("ready_after_done", 32'(cfg_ready_o), 32'd1);
    check("done_single", 32'(done_o | err_o), 32'd0);
  endtask

  initial begin : main
    int p, u, d, comp, cur_p, cur_c, k;

    // Reset defaults
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_acq", 32'(acq_period_o), 32'd215);
    check("rst_comp", 32'(bit_comp_o), 32'h77);
    check("rst_ready", 32'(cfg_ready_o), 32'd1);
    check("rst_outs", {uart_hold_o, done_o, err_o, err_code_o, meas_period_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean change, then a busy-wait change, then zero compensation
    run_change(107, 'h44, model_period(107, 'h44), 1'b0, 0);
    run_change(60, 'h23, model_period(60, 'h23), 1'b0, 60);
    run_change(50, 'h00, 51, 1'b0, 0);

    // Idle timeout: receiver stuck busy
    wait_ready();
    rx_busy_i = 1'b1;
    cfg_period_i = 12'd99;
    cfg_comp_i = 8'h11;
    cfg_valid_i = 1'b1;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    k = 1;
    while (!(err_o || done_o) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycle", 32'(k), 32'd101);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_code", 32'(err_code_o), 32'd1);
    check("tmo_hold", 32'(uart_hold_o), 32'd0);
    check("tmo_acq_kept", 32'(acq_period_o), 32'd50);
    check("tmo_comp_kept", 32'(bit_comp_o), 32'h00);
    rx_busy_i = 1'b0;
    @(negedge clk);
    check("tmo_ready_back", 32'(cfg_ready_o), 32'd1);
    check("tmo_code_holds", 32'(err_code_o), 32'd1);

`ifdef BAUD_CFG_VERIFY_EN
    // Generator forced to a wrong period
    force_per = 500;
    run_change(107, 'h44, 500, 1'b1, 0);
    force_per = 0;
    cur_p = 107;
    cur_c = 'h44;
`else
    cur_p = 50;
    cur_c = 'h00;
`endif

    // Random changes
    for (int n = 0; n < 5; n++) begin
      do begin
        p = int'($urandom_range(120, 20));
        u = int'($urandom_range(4, 0));
        d = int'($urandom_range(4, 0));
        comp = u * 16 + d;
      end while (p == cur_p && comp == cur_c);
      run_change(p, comp, model_period(p, comp), 1'b0, 0);
      cur_p = p;
      cur_c = comp;
    end

    // Reset while waiting for the latch pulse
    wait_ready();
    cfg_period_i = 12'd33;
    cfg_comp_i = 8'h21;
    cfg_valid_i = 1'b1;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    k = 0;
    while (acq_period_o != 12'd33 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("latch_reached", 32'(acq_period_o), 32'd33);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_acq", 32'(acq_period_o), 32'd215);
    check("mid_rst_comp", 32'(bit_comp_o), 32'h77);
    check("mid_rst_ready", 32'(cfg_ready_o), 32'd1);
    check("mid_rst_outs", {uart_hold_o, done_o, err_o, err_code_o, meas_period_o}, 32'd0);
    run_change(80, 'h32, model_period(80, 'h32), 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
